alu_secuenciador: RTL
=====================

ALU_SECUENCIADOR -- requirements
Module: alu_secuenciador

Interface
REQ-001 The block SHALL have parameter NUMPAR, default 8, giving the operand/result width in bits.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-004 The ports req0_valid and req1_valid SHALL be inputs, 1 bit each: requester X presents an operation.
REQ-005 The ports req0_op and req1_op SHALL be inputs, 5 bits each: requester X opcode.
REQ-006 The ports req0_a, req0_b, req1_a and req1_b SHALL be inputs, NUMPAR bits each: requester X operands.
REQ-007 The ports req0_ready and req1_ready SHALL be outputs, 1 bit each: requester X request accepted this cycle.
REQ-008 The port alu_codigoOP SHALL be an output, 5 bits wide: opcode driven to the shared ALU.
REQ-009 The ports alu_operandoA and alu_operandoB SHALL be outputs, NUMPAR bits each: operands driven to the ALU.
REQ-010 The port alu_resultado SHALL be an input, NUMPAR bits wide: ALU result.
REQ-011 The ports alu_N, alu_Z, alu_C and alu_V SHALL be inputs, 1 bit each: ALU flags.
REQ-012 The port resp_valid SHALL be an output, 1 bit wide: a response is presented.
REQ-013 The port resp_id SHALL be an output, 1 bit wide: the requester that owns the response.
REQ-014 The port resp_resultado SHALL be an output, NUMPAR bits wide: captured result.
REQ-015 The port resp_flags SHALL be an output, 4 bits wide: captured flags {N,Z,C,V}.
REQ-016 The port resp_err SHALL be an output, 1 bit wide: the opcode was unsupported.
REQ-017 The port resp_ready SHALL be an input, 1 bit wide: the consumer accepts the response.
REQ-018 The port busy SHALL be an output, 1 bit wide: the FSM is not IDLE.
REQ-019 The port op_count SHALL be an output, 16 bits wide: count of completed responses.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, CAPTURE and RESP, with transitions IDLE->ISSUE on acceptance, ISSUE->CAPTURE unconditionally, CAPTURE->RESP unconditionally, RESP->IDLE on resp_valid&resp_ready, and RESP held otherwise.
REQ-021 In IDLE the arbiter SHALL grant one valid requester; if only one is valid, that one is granted; if both are valid, the requester opposite the last granted one is granted (round-robin); if neither is valid, no grant is made.
REQ-022 reqX_ready SHALL be asserted combinationally only in IDLE and only for the granted requester; at most one ready SHALL be high; no ready SHALL be high outside IDLE.
REQ-023 On reqX_valid&reqX_ready the block SHALL latch op, a, b and id=X into internal registers and update the last-granted pointer to X.
REQ-024 alu_codigoOP, alu_operandoA and alu_operandoB SHALL be driven from the latched registers in every state and SHALL hold their last value while IDLE.
REQ-025 The ISSUE state SHALL be a one-cycle ALU settle; in CAPTURE the block SHALL register alu_resultado and {alu_N,alu_Z,alu_C,alu_V} into the resp_* registers.
REQ-026 Supported opcodes SHALL be 00000 add, 00001 sub, 00010 mult, 00101 and, 00110 or, 01000 xor and 01010 div; for any other opcode, CAPTURE SHALL set resp_err=1, resp_resultado=0 and resp_flags=0, otherwise resp_err=0.
REQ-027 Latency: with acceptance at edge t0, resp_valid SHALL go high after edge t0+3; with resp_ready held high, back-to-back throughput SHALL be one operation per 4 cycles.
REQ-028 resp_valid SHALL be high only in RESP; resp_id, resp_resultado, resp_flags and resp_err SHALL remain stable while resp_valid=1 and resp_ready=0.
REQ-029 On the resp handshake, op_count SHALL increment by 1, including error responses, and SHALL wrap from 16'hFFFF to 0.
REQ-030 busy SHALL be (state != IDLE).
REQ-031 A requester deasserting valid before acceptance SHALL have no effect; an accepted request SHALL not be cancellable.

Reset
REQ-032 When rst=1 at a rising edge, the block SHALL force state=IDLE, the last-granted pointer to 1 (req0 favored first), all latched registers, alu_* outputs, resp_* outputs and op_count to 0, and busy=0.
REQ-033 Reset asserted in any state SHALL discard the in-flight operation with no response and no op_count change; while rst=1, both reqX_ready SHALL be 0.

Verification (NUMPAR=8, ALU behavioral model attached)
REQ-034 The bench SHALL drive req0 with op=00000, a=8'h7F, b=8'h01, resp_ready=1 -> response 3 cycles after acceptance: resp_id=0, resp_resultado=8'h80, resp_flags=4'b1001, resp_err=0, op_count=1.
REQ-035 The bench SHALL hold both requesters valid continuously with resp_ready=1 -> grants 0,1,0,1, four responses within 16 cycles, and never both readys high.
REQ-036 The bench SHALL issue req1 with op=5'b11111 -> resp_err=1, resp_resultado=0, resp_flags=0, resp_id=1, and op_count incremented.
REQ-037 The bench SHALL hold resp_ready=0 for 5 cycles during RESP -> resp_valid and all resp_* stable, both readys 0, busy=1; then resp_ready=1 -> IDLE next cycle.
REQ-038 The bench SHALL assert rst for 1 cycle while in CAPTURE -> next cycle all outputs 0, no resp_valid, and op_count unchanged at 0.

Source files
------------

// File: rtl/alu_secuenciador.sv
// Two-requester front end for one shared ALU.
// Round-robin grant, fixed 4-state issue/capture/response sequence.
module alu_secuenciador #(
  parameter int NUMPAR = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [4:0]        req0_op,
  input  logic [NUMPAR-1:0] req0_a,
  input  logic [NUMPAR-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_op,
  input  logic [NUMPAR-1:0] req1_a,
  input  logic [NUMPAR-1:0] req1_b,
  output logic              req1_ready,
  output logic [4:0]        alu_codigoOP,
  output logic [NUMPAR-1:0] alu_operandoA,
  output logic [NUMPAR-1:0] alu_operandoB,
  input  logic [NUMPAR-1:0] alu_resultado,
  input  logic              alu_N,
  input  logic              alu_Z,
  input  logic              alu_C,
  input  logic              alu_V,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [NUMPAR-1:0] resp_resultado,
  output logic [3:0]        resp_flags,
  output logic              resp_err,
  input  logic              resp_ready,
  output logic              busy,
  output logic [15:0]       op_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              last;
  logic              gnt0;
  logic              gnt1;
  logic              op_ok;
  logic [4:0]        op_q;
  logic [NUMPAR-1:0] a_q;
  logic [NUMPAR-1:0] b_q;
  logic              id_q;

  // last=1 means req1 won most recently, so req0 wins a tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      gnt0 = req0_valid & (~req1_valid | last);
      gnt1 = req1_valid & (~req0_valid | ~last);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt0 | gnt1) state_nx = ISSUE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    op_ok = 1'b0;
    case (op_q)
      5'b00000, 5'b00001, 5'b00010,
      5'b00101, 5'b00110, 5'b01000,
      5'b01010: op_ok = 1'b1;
      default:  op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last           <= 1'b1;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      id_q           <= 1'b0;
      resp_id        <= 1'b0;
      resp_resultado <= '0;
      resp_flags     <= '0;
      resp_err       <= 1'b0;
      op_count       <= '0;
    end else begin
      state <= state_nx;
      if (gnt0) begin
        op_q <= req0_op;
        a_q  <= req0_a;
        b_q  <= req0_b;
        id_q <= 1'b0;
        last <= 1'b0;
      end else if (gnt1) begin
        op_q <= req1_op;
        a_q  <= req1_a;
        b_q  <= req1_b;
        id_q <= 1'b1;
        last <= 1'b1;
      end
      if (state == CAPTURE) begin
        resp_id <= id_q;
        if (op_ok) begin
          resp_resultado <= alu_resultado;
          resp_flags     <= {alu_N, alu_Z, alu_C, alu_V};
          resp_err       <= 1'b0;
        end else begin
          resp_resultado <= '0;
          resp_flags     <= '0;
          resp_err       <= 1'b1;
        end
      end
      if (state == RESP && resp_ready)
        op_count <= op_count + 16'd1;
    end
  end

  assign alu_codigoOP  = op_q;
  assign alu_operandoA = a_q;
  assign alu_operandoB = b_q;
  assign resp_valid    = (state == RESP);
  assign busy          = (state != IDLE);

endmodule
